// File: rtl/matrix_loader.sv
// Reads a size word plus two N x N matrices from a 2-cycle-latency RAM into
// register arrays, then streams (A[i], B[i]) pairs over a valid/ready handshake.
module matrix_loader #(
  parameter int DATA_W = 8,
  parameter int MAX_N  = 5,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [4:0]        out_idx,
  output logic              out_last
);
  localparam int DEPTH = MAX_N * MAX_N;

  typedef enum logic [1:0] {IDLE, RD_SIZE, LOAD, STREAM} state_t;
  state_t state, state_next;

  logic              busy_next, done_next, err_next, rden_next, valid_next;
  logic              size_wait, size_wait_next;
  logic              p1_valid, p1_valid_next;
  logic [ADDR_W-1:0] p1_addr, p1_addr_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] size_next;
  logic [4:0]        idx_next;
  logic [ADDR_W-1:0] nn, total, a_off, b_off;
  logic              cap_a, cap_last, wr_a, wr_b;
  logic [DEPTH-1:0]  sel_a, sel_b;
  logic [DATA_W-1:0] a_mem [DEPTH];
  logic [DATA_W-1:0] b_mem [DEPTH];

  // Address arithmetic kept in ADDR_W bits; 2*N*N is at most 50 for N<=5.
  assign nn    = ADDR_W'(size) * ADDR_W'(size);
  assign total = nn + nn;
  assign a_off = p1_addr - ADDR_W'(1);
  assign b_off = p1_addr - nn - ADDR_W'(1);

  assign cap_a    = (p1_addr <= nn);
  assign cap_last = p1_valid && (p1_addr == total);
  assign wr_a     = (state == LOAD) && p1_valid && cap_a;
  assign wr_b     = (state == LOAD) && p1_valid && !cap_a;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
    assign sel_a[gi] = wr_a && (a_off == ADDR_W'(gi));
    assign sel_b[gi] = wr_b && (b_off == ADDR_W'(gi));
  end

  // Element storage needs no reset: STREAM is only reached after a full load.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (sel_a[k]) a_mem[k] <= mem_q;
      if (sel_b[k]) b_mem[k] <= mem_q;
    end
  end

  assign out_a    = out_valid ? a_mem[out_idx] : '0;
  assign out_b    = out_valid ? b_mem[out_idx] : '0;
  assign out_last = out_valid && (ADDR_W'(out_idx) == nn - ADDR_W'(1));

  always_comb begin
    state_next     = state;
    busy_next      = busy;
    done_next      = 1'b0;
    err_next       = 1'b0;
    size_next      = size;
    addr_next      = mem_addr;
    rden_next      = mem_rden;
    valid_next     = out_valid;
    idx_next       = out_idx;
    size_wait_next = 1'b0;
    p1_valid_next  = 1'b0;
    p1_addr_next   = p1_addr;
    case (state)
      IDLE: begin
        if (start) begin
          addr_next      = '0;
          rden_next      = 1'b1;
          busy_next      = 1'b1;
          size_wait_next = 1'b1;
          state_next     = RD_SIZE;
        end
      end
      RD_SIZE: begin
        // First cycle only waits out the RAM latency for address 0.
        if (!size_wait) begin
          size_next = mem_q;
          if (mem_q == '0 || mem_q > DATA_W'(MAX_N)) begin
            err_next   = 1'b1;
            busy_next  = 1'b0;
            rden_next  = 1'b0;
            state_next = IDLE;
          end else begin
            addr_next  = ADDR_W'(1);
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (mem_rden) begin
          p1_valid_next = 1'b1;
          p1_addr_next  = mem_addr;
          if (mem_addr == total) rden_next = 1'b0;
          else                   addr_next = mem_addr + ADDR_W'(1);
        end
        // Stream starts on the very edge that captures B[N*N-1].
        if (cap_last) begin
          state_next = STREAM;
          valid_next = 1'b1;
          idx_next   = '0;
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (out_last) begin
            valid_next = 1'b0;
            done_next  = 1'b1;
            busy_next  = 1'b0;
            idx_next   = '0;
            state_next = IDLE;
          end else begin
            idx_next = out_idx + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      size      <= '0;
      mem_addr  <= '0;
      mem_rden  <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      size_wait <= 1'b0;
      p1_valid  <= 1'b0;
      p1_addr   <= '0;
    end else begin
      state     <= state_next;
      busy      <= busy_next;
      done      <= done_next;
      err       <= err_next;
      size      <= size_next;
      mem_addr  <= addr_next;
      mem_rden  <= rden_next;
      out_valid <= valid_next;
      out_idx   <= idx_next;
      size_wait <= size_wait_next;
      p1_valid  <= p1_valid_next;
      p1_addr   <= p1_addr_next;
    end
  end
endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: RAM model with 2-edge read latency and
// hand-built matrix images, checked by immediate assertions.
module tb_matrix_loader;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, err, mem_rden, out_valid, out_ready, out_last;
  logic [7:0] size, mem_addr, mem_q, out_a, out_b;
  logic [4:0] out_idx;

  logic [7:0] ram [256];
  int         exp_a [25];
  int         exp_b [25];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  // Address registered at the edge after issue, data sampled one edge later.
  initial mem_q = 8'd0;
  always @(posedge clk) if (mem_rden) mem_q <= ram[mem_addr];

  matrix_loader #(.DATA_W(8), .MAX_N(5), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .err(err), .size(size), .mem_addr(mem_addr), .mem_rden(mem_rden),
    .mem_q(mem_q), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_idx(out_idx), .out_last(out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] acc;
    acc = {busy, done, err, mem_rden, out_valid, out_last} | size | mem_addr
          | out_a | out_b | out_idx;
    check(tag, acc, 0);
  endtask

  // mode 0: A[k]=k+1, B[k]=10*(k+1); mode 1: A[k]=k, B[k]=255-k
  task automatic load_image(input int n, input int mode);
    for (int k = 0; k < 256; k++) ram[k] = 8'hEE;
    ram[0] = 8'(n);
    for (int k = 0; k < n * n; k++) begin
      exp_a[k] = (mode == 0) ? k + 1 : k;
      exp_b[k] = (mode == 0) ? 10 * (k + 1) : 255 - k;
      ram[1 + k]         = 8'(exp_a[k]);
      ram[1 + n * n + k] = 8'(exp_b[k]);
    end
  endtask

  task automatic run_load(input int n, input int stall_idx, input int stall_cycles,
                          input bit restart, input bit sum_chk);
    int nn, pairs, dones, errs, next_addr, last_addr, addr_bad, stalls, post;
    bit restarted;
    nn = n * n; pairs = 0; dones = 0; errs = 0; next_addr = 0; last_addr = -1;
    addr_bad = 0; stalls = 0; post = 0; restarted = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_on_start", busy, 1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (mem_rden && int'(mem_addr) != last_addr) begin
        if (int'(mem_addr) != next_addr) addr_bad++;
        last_addr = int'(mem_addr);
        next_addr++;
      end
      if (done) dones++;
      if (err) errs++;
      if (out_valid) begin
        check("out_idx", out_idx, pairs);
        check("out_a", out_a, exp_a[pairs]);
        check("out_b", out_b, exp_b[pairs]);
        check("out_last", out_last, pairs == nn - 1);
        if (sum_chk) check("a_plus_b", 32'(out_a) + 32'(out_b), 255);
        if (restart && pairs == 1 && !restarted) begin
          start = 1'b1;
          restarted = 1'b1;
        end else start = 1'b0;
        if (pairs == stall_idx && stalls < stall_cycles) begin
          out_ready = 1'b0;
          stalls++;
        end else out_ready = 1'b1;
        if (out_ready) pairs++;
      end else begin
        start = 1'b0;
        out_ready = 1'b1;
      end
      if (dones > 0) post++;
      if (post >= 3) break;
      tick();
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("pairs_streamed", pairs, nn);
    check("done_pulses", dones, 1);
    check("err_pulses", errs, 0);
    check("addr_order_bad", addr_bad, 0);
    check("addrs_issued", next_addr, 2 * nn + 1);
    check("last_addr", last_addr, 2 * nn);
    check("stall_cycles", stalls, stall_cycles);
    check("size_out", size, n);
    check("busy_end", busy, 0);
    check("valid_end", out_valid, 0);
  endtask

  task automatic run_bad(input int n);
    int bad;
    bad = 0;
    ram[0] = 8'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bad_addr0", mem_addr, 0);
    check("bad_rden0", mem_rden, 1);
    check("bad_busy0", busy, 1);
    tick();
    check("bad_err_early", err, 0);
    tick();
    check("bad_err_pulse", err, 1);
    check("bad_busy_clear", busy, 0);
    check("bad_rden_clear", mem_rden, 0);
    check("bad_size", size, n);
    for (int c = 0; c < 8; c++) begin
      tick();
      if (err || out_valid || busy || (mem_rden && mem_addr != 8'd0)) bad++;
    end
    check("bad_quiet_after", bad, 0);
  endtask

  initial begin
    int found;
    rst_n = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 256; k++) ram[k] = 8'h00;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset_outputs");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check_all_zero("idle_after_reset");

    $display("step: N=2 basic stream");
    load_image(2, 0);
    run_load(2, -1, 0, 1'b0, 1'b0);

    $display("step: illegal sizes N=0 and N=6");
    run_bad(0);
    run_bad(6);

    $display("step: N=2 with 3-cycle stall at idx 1");
    load_image(2, 0);
    run_load(2, 1, 3, 1'b0, 1'b0);

    $display("step: N=5 full matrix");
    load_image(5, 1);
    run_load(5, -1, 0, 1'b0, 1'b1);

    $display("step: reset during LOAD at mem_addr=3");
    load_image(2, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      if (mem_addr == 8'd3 && mem_rden) begin
        found = 1;
        break;
      end
      tick();
    end
    check("reached_addr3", found, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset_mid_load");
    @(posedge clk);
    #1 check_all_zero("held_in_reset");
    rst_n = 1'b1;
    tick();
    check_all_zero("idle_after_abort");
    run_load(2, -1, 0, 1'b0, 1'b0);

    $display("step: start ignored during STREAM");
    load_image(2, 0);
    run_load(2, -1, 0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameters SHALL be: DATA_W, 8, element and size-word width; MAX_N, 5, largest legal matrix dimension; ADDR_W, 8, RAM address width.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset: clk  in  1  clock, all state on rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-003 Ports SHALL be:
- start  in  1  single-cycle load request
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse at end of stream
- err  out  1  one-cycle pulse on illegal size
- size  out  DATA_W  captured dimension N
- mem_addr  out  ADDR_W  RAM read address
- mem_rden  out  1  RAM read enable
- mem_q  in  DATA_W  RAM read data
- out_valid  out  1  element pair valid
- out_ready  in  1  downstream accepts pair
- out_a  out  DATA_W  element of A
- out_b  out  DATA_W  element of B
- out_idx  out  5  linear element index, 0..N*N-1
- out_last  out  1  high with final pair

Function
REQ-004 RAM layout SHALL be: address 0 = N; addresses 1..N*N = A, row-major; addresses N*N+1..2*N*N = B, row-major.
REQ-005 RAM read latency SHALL be 2 edges: data for the mem_addr driven after edge k is captured from mem_q at edge k+2.
REQ-006 States SHALL be IDLE, RD_SIZE, LOAD, STREAM.
REQ-007 In IDLE, start=1 at an edge SHALL drive mem_addr=0 and mem_rden=1, set busy=1, and enter RD_SIZE.
- start while busy=1 is ignored.
REQ-008 In RD_SIZE, the word at mem_q SHALL be captured into size two edges after address 0 was issued.
- N=0 or N>MAX_N: pulse err for one cycle, clear busy and mem_rden, return to IDLE.
- Otherwise drive mem_addr=1 on that same edge and enter LOAD.
REQ-009 In LOAD:
- one address SHALL be issued per cycle, from 1 to 2*N*N.
- a 2-stage valid pipeline SHALL tag each capture as A (index addr-1) or B (index addr-N*N-1).
- mem_rden SHALL drop after the final address is issued.
- the state SHALL advance to STREAM on the edge that captures B[N*N-1].
REQ-010 Storage SHALL be two MAX_N*MAX_N x DATA_W register arrays; entries at or beyond N*N are not written.
REQ-011 N*N and 2*N*N SHALL be computed in at least ADDR_W bits; for N<=5 the maximum address is 50, with no wrap.
REQ-012 In STREAM:
- out_valid=1, with out_a=A[i], out_b=B[i], out_idx=i, and out_last=(i==N*N-1).
- i advances only on an edge where out_valid and out_ready are both 1.
- outputs SHALL hold stable while out_ready=0.
REQ-013 The handshake on the last pair SHALL deassert out_valid, pulse done for one cycle, clear busy, and return to IDLE.
REQ-014 The LOAD-to-STREAM transition SHALL take zero added cycles: out_valid rises on the edge that captures the last B element.
REQ-015 RAM writes SHALL NOT be issued; the block is read-only toward memory.

Reset
REQ-016 rst_n=0 SHALL immediately force IDLE with all outputs 0: busy, done, err, size, mem_addr, mem_rden, out_valid, out_a, out_b, out_idx, out_last.
REQ-017 The element arrays SHALL need no reset; stale contents are never presented because STREAM is reached only after a full load.
REQ-018 Reset asserted mid-RD_SIZE, LOAD, or STREAM SHALL abort with no done or err pulse; the next start performs a complete reload.

Verification
REQ-019 N=2, RAM=[2, 1,2,3,4, 10,20,30,40], out_ready=1:
- pairs (1,10),(2,20),(3,30),(4,40) on idx 0..3, out_last only on idx 3.
- mem_addr 0..8 each issued once, then a single done pulse.
REQ-020 N=0, and separately N=6: err pulses once two edges after address 0, no out_valid, busy clears, and addresses beyond 0 are never issued.
REQ-021 N=2 with out_ready held 0 for 3 cycles at idx 1: out_a=2, out_b=20, out_idx=1 stay stable, and no pair is skipped or duplicated.
REQ-022 N=5, A[k]=k, B[k]=255-k: 25 pairs with out_a+out_b=255 for every pair, last mem_addr=50, out_last at idx 24.
REQ-023 rst_n pulsed low during LOAD at mem_addr=3:
- all outputs return to 0 asynchronously, before the next edge.
- a subsequent start on the N=2 image reproduces the REQ-019 sequence exactly.
REQ-024 start pulsed again during STREAM: ignored, and the stream completes with exactly one done pulse.
